countdown_monitor: RTL and testbench

//  Receive-side checker for a modulo-(MAX_VAL+1) down-counter bus (MAX_VAL, MAX_VAL-1 .. 0, MAX_VAL ..).

---
 rtl/countdown_pkg.sv | 39 +++
 rtl/sat_counter.sv | 26 ++
 rtl/countdown_monitor.sv | 158 +++++++++++++++
 tb/tb_countdown_monitor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types for the countdown monitor: tracking states, step classes and error codes.
// err_code values are part of the block's visible interface, so they are fixed here once.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    STEP_ILLEGAL = 3'd0,
    STEP_PRESET  = 3'd1,
    STEP_GOOD    = 3'd2,
    STEP_HOLD    = 3'd3,
    STEP_SKIP    = 3'd4
  } step_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SKIP    = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_HOLD    = 2'b11;

  function automatic logic step_is_legal(step_e step);
    return (step == STEP_PRESET) || (step == STEP_GOOD);
  endfunction

  function automatic logic [1:0] step_err_code(step_e step);
    logic [1:0] code;
    case (step)
      STEP_ILLEGAL: code = ERR_ILLEGAL;
      STEP_HOLD:    code = ERR_HOLD;
      STEP_SKIP:    code = ERR_SKIP;
      default:      code = ERR_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones instead of wrapping back to zero.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_q <= q_q + W'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/countdown_monitor.sv
// Receive-side checker for a modulo-(MAX_VAL+1) down-counter bus: locks onto the
// sequence, flags wraps and deviations, and counts completed periods.
module countdown_monitor
  import countdown_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned MAX_VAL  = 10,
  parameter int unsigned LOCK_LEN = 3,
  parameter int unsigned PCNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W-1:0]      cnt_in,
  input  logic              preset_in,
  output logic              locked,
  output logic              wrap_pulse,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic [PCNT_W-1:0] period_count,
  output logic [W-1:0]      expected
);

  localparam logic [W-1:0] MAX_W  = W'(MAX_VAL);
  localparam logic [3:0]   LOCK_W = 4'(LOCK_LEN);

  state_e       state_q, state_d;
  logic [W-1:0] prev_q, prev_d;
  logic [3:0]   good_cnt_q, good_cnt_d;
  logic         locked_q, locked_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;
  logic [1:0]   err_code_q, err_code_d;
  logic [W-1:0] expected_q, expected_d;

  logic [W-1:0] exp_cur;
  step_e        step;

  // Down-count prediction; zero reloads to MAX_VAL rather than underflowing.
  function automatic logic [W-1:0] predict(logic [W-1:0] p);
    return (p == '0) ? MAX_W : (p - W'(1));
  endfunction

  assign exp_cur = predict(prev_q);

  // Classification priority matters: a preset to MAX_VAL is never treated as a wrap.
  always_comb begin
    if (cnt_in > MAX_W) begin
      step = STEP_ILLEGAL;
    end else if (preset_in && (cnt_in == MAX_W)) begin
      step = STEP_PRESET;
    end else if (cnt_in == exp_cur) begin
      step = STEP_GOOD;
    end else if (cnt_in == prev_q) begin
      step = STEP_HOLD;
    end else begin
      step = STEP_SKIP;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    good_cnt_d = good_cnt_q;
    locked_d   = locked_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (step != STEP_ILLEGAL) begin
          prev_d     = cnt_in;
          good_cnt_d = '0;
          state_d    = ST_ACQ;
        end
      end
      ST_ACQ: begin
        if (step_is_legal(step)) begin
          good_cnt_d = good_cnt_q + 4'd1;
          if (good_cnt_d == LOCK_W) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end
        end else begin
          good_cnt_d = '0;
          if (step == STEP_ILLEGAL) begin
            state_d = ST_IDLE;
          end
        end
        if (step != STEP_ILLEGAL) begin
          prev_d = cnt_in;
        end
      end
      ST_LOCKED: begin
        if (step_is_legal(step)) begin
          wrap_d = (step == STEP_GOOD) && (prev_q == '0);
        end else begin
          err_d      = 1'b1;
          err_code_d = step_err_code(step);
          locked_d   = 1'b0;
          good_cnt_d = '0;
          state_d    = (step == STEP_ILLEGAL) ? ST_IDLE : ST_ACQ;
        end
        if (step != STEP_ILLEGAL) begin
          prev_d = cnt_in;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        locked_d   = 1'b0;
        good_cnt_d = '0;
      end
    endcase

    expected_d = predict(prev_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      expected_q <= MAX_W;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_cnt_q <= good_cnt_d;
      locked_q   <= locked_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      expected_q <= expected_d;
    end
  end

  // Increments on the same edge that raises wrap_pulse.
  sat_counter #(
    .W(PCNT_W)
  ) u_period_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (wrap_d),
    .q    (period_count)
  );

  assign locked     = locked_q;
  assign wrap_pulse = wrap_q;
  assign err_pulse  = err_q;
  assign err_code   = err_code_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_countdown_monitor.sv
// Bench for countdown_monitor: directed scenarios plus a random count stream, checked every
// cycle against a behavioural model; two instances cover wide and 2-bit period counters.
module tb_countdown_monitor;

  localparam int W    = 4;
  localparam int MAX  = 10;
  localparam int LL   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_in;
  logic       preset_in;

  logic       a_locked, a_wrap, a_err;
  logic [1:0] a_code;
  logic [7:0] a_period;
  logic [3:0] a_expected;
  logic       b_locked, b_wrap, b_err;
  logic [1:0] b_code;
  logic [1:0] b_period;
  logic [3:0] b_expected;

  always #5 clk = ~clk;

  countdown_monitor #(.W(W), .MAX_VAL(MAX), .LOCK_LEN(LL), .PCNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .preset_in(preset_in),
    .locked(a_locked), .wrap_pulse(a_wrap), .err_pulse(a_err), .err_code(a_code),
    .period_count(a_period), .expected(a_expected)
  );

  countdown_monitor #(.W(W), .MAX_VAL(MAX), .LOCK_LEN(LL), .PCNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .preset_in(preset_in),
    .locked(b_locked), .wrap_pulse(b_wrap), .err_pulse(b_err), .err_code(b_code),
    .period_count(b_period), .expected(b_expected)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: the monitor's view of the stream in plain integers.
  bit m_idle, m_locked, m_wrap, m_err;
  int m_prev, m_run, m_code, m_p8, m_p2;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  function automatic int pred(input int p);
    return (p == 0) ? MAX : p - 1;
  endfunction

  task automatic model_update(input bit r, input int s, input bit p);
    int  e;
    bit  ill, pre, good, legal;
    int  code;
    m_wrap = 0;
    m_err  = 0;
    if (r) begin
      m_idle = 1; m_locked = 0; m_prev = 0; m_run = 0;
      m_code = 0; m_p8 = 0; m_p2 = 0;
      return;
    end
    e     = pred(m_prev);
    ill   = (s > MAX);
    pre   = p && (s == MAX);
    good  = (s == e);
    legal = !ill && (pre || good);
    if (ill)                 code = 2;
    else if (legal)          code = 0;
    else if (s == m_prev)    code = 3;
    else                     code = 1;

    if (m_idle) begin
      if (!ill) begin
        m_prev = s;
        m_idle = 0;
        m_run  = 0;
      end
      return;
    end
    if (legal) begin
      if (m_locked) begin
        if (good && !pre && m_prev == 0) begin
          m_wrap = 1;
          m_p8   = (m_p8 < 255) ? m_p8 + 1 : 255;
          m_p2   = (m_p2 < 3) ? m_p2 + 1 : 3;
        end
      end else begin
        m_run++;
        if (m_run == LL) m_locked = 1;
      end
    end else begin
      if (m_locked) begin
        m_err    = 1;
        m_code   = code;
        m_locked = 0;
      end
      m_run = 0;
      if (ill) m_idle = 1;
    end
    if (!ill) m_prev = s;
  endtask

  task automatic compare_all();
    check("locked",       int'(a_locked),   int'(m_locked));
    check("wrap_pulse",   int'(a_wrap),     int'(m_wrap));
    check("err_pulse",    int'(a_err),      int'(m_err));
    check("err_code",     int'(a_code),     m_code);
    check("period_count", int'(a_period),   m_p8);
    check("expected",     int'(a_expected), pred(m_prev));
    check("b_locked",     int'(b_locked),   int'(m_locked));
    check("b_wrap",       int'(b_wrap),     int'(m_wrap));
    check("b_err_code",   int'(b_code),     m_code);
    check("b_period",     int'(b_period),   m_p2);
  endtask

  // Called at a falling edge: drive, let the rising edge sample, compare at the next fall.
  task automatic step(input bit r, input int s, input bit p);
    reset     = r;
    cnt_in    = 4'(s);
    preset_in = p;
    @(posedge clk);
    model_update(r, s, p);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int c;
    int v;
    int r;
    reset = 1'b1; cnt_in = '0; preset_in = 1'b0;
    m_idle = 1;
    @(negedge clk);

    // Reset values
    step(1, 0, 0);
    step(1, 0, 0);
    check("rst_locked",   int'(a_locked), 0);
    check("rst_expected", int'(a_expected), 10);
    check("rst_period",   int'(a_period), 0);

    // Acquire, lock on the third legal step after IDLE, then count periods
    step(0, 10, 0);
    step(0, 9, 0);
    step(0, 8, 0);
    check("t1_not_yet_locked", int'(a_locked), 0);
    step(0, 7, 0);
    check("t1_locked", int'(a_locked), 1);
    for (int k = 6; k >= 0; k--) step(0, k, 0);
    step(0, 10, 0);
    check("t1_first_wrap",   int'(a_wrap), 1);
    check("t1_period_1",     int'(a_period), 1);
    check("t6_b_period_1",   int'(b_period), 1);
    for (int per = 2; per <= 5; per++) begin
      for (int k = 9; k >= 0; k--) begin
        step(0, k, 0);
        if (k == 9) check("t1_wrap_one_cycle", int'(a_wrap), 0);
      end
      step(0, 10, 0);
      check("t1_wrap",       int'(a_wrap), 1);
      check("t1_period",     int'(a_period), per);
      check("t6_b_period",   int'(b_period), (per > 3) ? 3 : per);
    end

    // Skip: 7 where 5 is expected
    step(0, 9, 0); step(0, 8, 0); step(0, 7, 0); step(0, 6, 0);
    step(0, 7, 0);
    check("t2_err_pulse", int'(a_err), 1);
    check("t2_err_code",  int'(a_code), 1);
    check("t2_unlocked",  int'(a_locked), 0);
    step(0, 6, 0);
    check("t2_err_one_cycle", int'(a_err), 0);
    step(0, 5, 0);
    check("t2_not_relocked", int'(a_locked), 0);
    step(0, 4, 0);
    check("t2_relocked", int'(a_locked), 1);

    // Illegal value while locked at 4
    step(0, 12, 0);
    check("t3_err_code", int'(a_code), 2);
    check("t3_err_pulse", int'(a_err), 1);
    check("t3_no_wrap",  int'(a_wrap), 0);
    step(0, 9, 0);
    step(0, 8, 0);
    step(0, 7, 0);
    check("t3_not_yet_locked", int'(a_locked), 0);
    step(0, 6, 0);
    check("t3_relocked", int'(a_locked), 1);

    // Preset while locked at 6
    step(0, 10, 1);
    check("t4_no_err",   int'(a_err), 0);
    check("t4_no_wrap",  int'(a_wrap), 0);
    check("t4_expected", int'(a_expected), 9);
    step(0, 9, 0); step(0, 8, 0); step(0, 7, 0); step(0, 6, 0);
    step(0, 5, 1);
    check("t4_preset_ignored_locked", int'(a_locked), 1);
    check("t4_preset_ignored_exp",    int'(a_expected), 4);

    // Hold at 3
    step(0, 4, 0); step(0, 3, 0);
    step(0, 3, 0);
    check("t5_err_code",  int'(a_code), 3);
    check("t5_err_pulse", int'(a_err), 1);
    step(0, 3, 0);
    check("t5_no_second_pulse", int'(a_err), 0);
    check("t5_still_unlocked",  int'(a_locked), 0);
    step(0, 2, 0); step(0, 1, 0); step(0, 0, 0);
    check("t5_relocked", int'(a_locked), 1);
    step(0, 10, 0);
    check("t5_wrap", int'(a_wrap), 1);

    // Lock-entry edge coinciding with a 0 -> MAX step does not wrap
    step(1, 0, 0);
    step(0, 2, 0); step(0, 1, 0); step(0, 0, 0); step(0, 10, 0);
    check("lock_entry_locked", int'(a_locked), 1);
    check("lock_entry_no_wrap", int'(a_wrap), 0);

    // Reset mid-period
    step(0, 9, 0); step(0, 8, 0);
    step(1, 5, 0);
    check("t6_rst_locked",   int'(a_locked), 0);
    check("t6_rst_code",     int'(a_code), 0);
    check("t6_rst_period",   int'(a_period), 0);
    check("t6_rst_b_period", int'(b_period), 0);
    check("t6_rst_expected", int'(a_expected), 10);

    // Random stream: mostly a proper count with injected faults
    c = 10;
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        step(1, c, 0);
      end else if (r < 86) begin
        c = (c == 0) ? 10 : c - 1;
        step(0, c, 0);
      end else if (r < 90) begin
        c = 10;
        step(0, 10, 1);
      end else if (r < 93) begin
        step(0, c, 0);
      end else if (r < 96) begin
        c = int'($urandom_range(0, 10));
        step(0, c, 0);
      end else if (r < 98) begin
        step(0, int'($urandom_range(11, 15)), 0);
      end else begin
        v = int'($urandom_range(0, 10));
        c = v;
        step(0, v, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
